// File: rtl/clkgen_pkg.sv
// Shared constants and helpers for the clock divider bank.
package clkgen_pkg;

  localparam int MAX_CH     = 16;
  localparam int HALF_1HZ   = 49_999_999;
  localparam int HALF_100HZ = 499_999;
  localparam int HALF_10KHZ = 4_999;

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One programmable divider channel: half-period counter, 50 % square wave and toggle tick.
module clkdiv_channel
  import clkgen_pkg::*;
#(
  parameter int             CNT_W    = 24,
  parameter logic [CNT_W-1:0] DEF_HALF = 24'd4_999_999
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_en,
  input  logic [CNT_W-1:0] load_val,
  input  logic             sync,
  output logic             tc,
  output logic             clk_out,
  output logic             tick
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] half;

  assign tc = (cnt == half);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      half    <= DEF_HALF;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      // The top only raises load_en at terminal count or sync, so the period never tears.
      if (load_en) half <= load_val;
      if (sync) begin
        cnt     <= '0;
        clk_out <= 1'b0;
        tick    <= 1'b0;
      end else if (tc) begin
        cnt     <= '0;
        clk_out <= ~clk_out;
        tick    <= 1'b1;
      end else begin
        cnt  <= cnt + CNT_W'(1);
        tick <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/clock_divider_bank.sv
// Bank of NUM_CH divider channels with a shared reload slot and a display-scan counter.
// Optional CLKGEN_SYNC_EN adds a sync input that realigns every channel.
module clock_divider_bank
  import clkgen_pkg::*;
#(
  parameter int               NUM_CH   = 4,
  parameter int               CNT_W    = 24,
  parameter logic [CNT_W-1:0] DEF_HALF = 24'd4_999_999,
  parameter int               SCAN_W   = 17,
  parameter int               SEL_W    = 2,
  localparam int              CH_W     = ch_width(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_half,
  output logic              cfg_ready,
  output logic              cfg_err,
`ifdef CLKGEN_SYNC_EN
  input  logic              sync,
`endif
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [SEL_W-1:0]  scan_sel
);

  logic              pend_valid;
  logic [CH_W-1:0]   pend_ch;
  logic [CNT_W-1:0]  pend_half;
  logic [NUM_CH-1:0] tc;
  logic [NUM_CH-1:0] load_en;
  logic              applied;
  logic              sync_i;
  logic              accept;
  logic              bad_ch;
  logic [SCAN_W-1:0] scan_cnt;

`ifdef CLKGEN_SYNC_EN
  assign sync_i = sync;
`else
  assign sync_i = 1'b0;
`endif

  assign accept   = cfg_valid && cfg_ready;
  assign bad_ch   = 32'(cfg_ch) >= 32'(NUM_CH);
  assign scan_sel = scan_cnt[SCAN_W-1 -: SEL_W];

  // NOTE: outputs get defaults before the loop so no path leaves them unassigned (no latch).
  always_comb begin
    load_en = '0;
    applied = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (pend_valid && (pend_ch == CH_W'(i)) && (tc[i] || sync_i)) begin
        load_en[i] = 1'b1;
        applied    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_valid <= 1'b0;
      pend_ch    <= '0;
      pend_half  <= '0;
      cfg_ready  <= 1'b1;
      cfg_err    <= 1'b0;
      scan_cnt   <= '0;
    end else begin
      scan_cnt <= scan_cnt + SCAN_W'(1);
      cfg_err  <= accept && bad_ch;
      if (accept && !bad_ch) begin
        pend_valid <= 1'b1;
        pend_ch    <= cfg_ch;
        pend_half  <= cfg_half;
        cfg_ready  <= 1'b0;
      end else begin
        if (applied) pend_valid <= 1'b0;
        // Ready trails the slot by a cycle so the new half is live before the next request.
        cfg_ready <= !pend_valid;
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clkdiv_channel #(
      .CNT_W    (CNT_W),
      .DEF_HALF (DEF_HALF)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .load_en  (load_en[g]),
      .load_val (pend_half),
      .sync     (sync_i),
      .tc       (tc[g]),
      .clk_out  (clk_out[g]),
      .tick     (tick[g])
    );
  end

endmodule
